// File: rtl/fp_arith_pipe.sv
// Purpose: 3-stage floating-point add/sub/mul with tag passthrough and exception flags.
// Latency: 3 cycles from accept to out_valid when there is no stall; throughput 1 op/cycle.
// Backpressure: the whole pipe freezes while a result sits unaccepted; in_ready = ~s3_valid | out_ready.
//
// Ports:
//   clk, areset          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake; a, b (W bits), op (00 add, 01 sub, 10 mul, 11 reserved), in_tag
//   out_valid/out_ready  result handshake; result (W bits), out_tag, flags = {invalid, overflow, underflow}
module fp_arith_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic [1:0]           op,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [TAG_W-1:0]     out_tag,
  output logic [2:0]           flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int SW   = MAN_W + 4;            // hidden bit + fraction + guard/round/sticky
  localparam int PW   = 2 * MAN_W + 2;        // full significand product
  localparam int XW   = EXP_W + $clog2(SW + 1) + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;

  localparam logic signed [XW-1:0] X_ONE  = XW'(1);
  localparam logic signed [XW-1:0] X_ZERO = XW'(0);
  localparam logic signed [XW-1:0] X_EMAX = XW'(EMAX);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic [TAG_W-1:0]        tag;
    logic                    sp;       // result fully decided by special-value logic
    logic [W-1:0]            sp_res;
    logic [2:0]              sp_flg;
    logic                    is_mul;
    logic                    sign;
    logic                    eff_sub;
    logic signed [XW-1:0]    exp;
    logic [SW-1:0]           big;      // larger-magnitude significand, GRS appended
    logic [SW-1:0]           sml;      // aligned smaller significand, sticky in LSB
    logic [PW-1:0]           prod;
  } s1_t;

  typedef struct packed {
    logic [TAG_W-1:0]        tag;
    logic                    sp;
    logic [W-1:0]            sp_res;
    logic [2:0]              sp_flg;
    logic                    sign;
    logic                    zero;
    logic signed [XW-1:0]    exp;
    logic [SW-1:0]           nm;       // normalised: 1.frac G R S
  } s2_t;

  logic advance;
  logic s1_vld_q, s2_vld_q, s3_vld_q;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  logic [W-1:0]     res_d, result_q;
  logic [2:0]       flg_d, flg_q;
  logic [TAG_W-1:0] tag_q;

  assign advance   = ~s3_vld_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = s3_vld_q;
  assign result    = result_q;
  assign out_tag   = tag_q;
  assign flags     = flg_q;

  // ---------------- S1: unpack, classify, align / multiply ----------------
  logic               sa, sb, sb_eff;
  logic [EXP_W-1:0]   ea, eb, e_big, e_sml;
  logic [MAN_W-1:0]   fa, fb, fa_f, fb_f;
  logic               za, zb, ia, ib, na, nb, swap;
  logic [SW-1:0]      big_ext, sml_ext, sml_al;
  logic [XW-1:0]      d, dsat;
  logic [2*SW-1:0]    sh;
  logic [PW-1:0]      prod;
  logic signed [XW-1:0] exp_mul;

  assign sa = a[W-1];
  assign sb = b[W-1];
  assign ea = a[W-2:MAN_W];
  assign eb = b[W-2:MAN_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];
  assign za = (ea == '0);
  assign zb = (eb == '0);
  assign ia = (ea == '1) && (fa == '0);
  assign ib = (eb == '1) && (fb == '0);
  assign na = (ea == '1) && (fa != '0);
  assign nb = (eb == '1) && (fb != '0);
  // Subnormal inputs are flushed: fraction forced to zero along with the hidden bit.
  assign fa_f = za ? '0 : fa;
  assign fb_f = zb ? '0 : fb;
  assign sb_eff = sb ^ (op == 2'b01);

  assign swap    = {eb, fb_f} > {ea, fa_f};
  assign e_big   = swap ? eb : ea;
  assign e_sml   = swap ? ea : eb;
  assign big_ext = swap ? {~zb, fb_f, 3'b000} : {~za, fa_f, 3'b000};
  assign sml_ext = swap ? {~za, fa_f, 3'b000} : {~zb, fb_f, 3'b000};

  // Shift through a double-width window so everything that falls off lands in
  // the low half and collapses into the sticky bit.
  assign d      = XW'(e_big) - XW'(e_sml);
  assign dsat   = (d > XW'(SW - 1)) ? XW'(SW - 1) : d;
  assign sh     = {sml_ext, {SW{1'b0}}} >> dsat;
  assign sml_al = {sh[2*SW-1:SW+1], sh[SW] | (|sh[SW-1:0])};

  assign prod    = PW'({~za, fa_f}) * PW'({~zb, fb_f});
  assign exp_mul = $signed(XW'(ea)) + $signed(XW'(eb)) - XW'(BIAS);

  always_comb begin
    s1_d         = '0;
    s1_d.tag     = in_tag;
    s1_d.is_mul  = op[1];
    s1_d.eff_sub = sa ^ sb_eff;
    s1_d.big     = big_ext;
    s1_d.sml     = sml_al;
    s1_d.prod    = prod;
    if (op[1]) begin
      s1_d.sign = sa ^ sb;
      s1_d.exp  = exp_mul;
    end else begin
      s1_d.sign = swap ? sb_eff : sa;
      s1_d.exp  = $signed(XW'(e_big));
    end

    if (op == 2'b11) begin
      s1_d.sp = 1'b1; s1_d.sp_res = QNAN; s1_d.sp_flg = 3'b100;
    end else if (na | nb) begin
      s1_d.sp = 1'b1; s1_d.sp_res = QNAN;
    end else if (op[1]) begin
      if ((ia & zb) | (ib & za)) begin
        s1_d.sp = 1'b1; s1_d.sp_res = QNAN; s1_d.sp_flg = 3'b100;
      end else if (ia | ib) begin
        s1_d.sp = 1'b1; s1_d.sp_res = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (za | zb) begin
        s1_d.sp = 1'b1; s1_d.sp_res = {sa ^ sb, {(W-1){1'b0}}};
      end
    end else begin
      if (ia & ib) begin
        s1_d.sp = 1'b1;
        if (sa != sb_eff) begin
          s1_d.sp_res = QNAN; s1_d.sp_flg = 3'b100;
        end else begin
          s1_d.sp_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
      end else if (ia) begin
        s1_d.sp = 1'b1; s1_d.sp_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (ib) begin
        s1_d.sp = 1'b1; s1_d.sp_res = {sb_eff, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
    end
  end

  // ---------------- S2: add/sub, normalise ----------------
  logic [SW:0]          sum;
  logic signed [XW-1:0] lz;
  logic                 found;
  logic [PW-1:0]        pn;

  assign sum = s1_q.eff_sub ? ({1'b0, s1_q.big} - {1'b0, s1_q.sml})
                            : ({1'b0, s1_q.big} + {1'b0, s1_q.sml});
  // Product of two [1,2) significands lies in [1,4); pre-shift so the leading one is at the top.
  assign pn  = s1_q.prod[PW-1] ? s1_q.prod : (s1_q.prod << 1);

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!found && sum[i]) begin
        lz    = XW'(SW - 1 - i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    s2_d        = '0;
    s2_d.tag    = s1_q.tag;
    s2_d.sp     = s1_q.sp;
    s2_d.sp_res = s1_q.sp_res;
    s2_d.sp_flg = s1_q.sp_flg;
    s2_d.sign   = s1_q.sign;
    if (s1_q.is_mul) begin
      s2_d.exp = s1_q.exp + (s1_q.prod[PW-1] ? X_ONE : X_ZERO);
      s2_d.nm  = {pn[PW-1:MAN_W+1], pn[MAN_W], pn[MAN_W-1], |pn[MAN_W-2:0]};
    end else if (sum == '0) begin
      // Exact cancellation is +0; a same-sign zero sum keeps its sign.
      s2_d.zero = 1'b1;
      s2_d.sign = s1_q.eff_sub ? 1'b0 : s1_q.sign;
    end else if (sum[SW]) begin
      s2_d.exp = s1_q.exp + X_ONE;
      s2_d.nm  = {sum[SW:2], sum[1] | sum[0]};
    end else begin
      s2_d.exp = s1_q.exp - lz;
      s2_d.nm  = sum[SW-1:0] << lz;
    end
  end

  // ---------------- S3: round to nearest even, range check, pack ----------------
  logic                 rnd_up;
  logic [MAN_W+1:0]     mant;
  logic signed [XW-1:0] exp_r;
  logic [MAN_W-1:0]     frac;

  assign rnd_up = s2_q.nm[2] & (s2_q.nm[1] | s2_q.nm[0] | s2_q.nm[3]);
  assign mant   = {1'b0, s2_q.nm[SW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
  // A rounding carry-out means the significand became 10.000..., bump the exponent.
  assign exp_r  = s2_q.exp + (mant[MAN_W+1] ? X_ONE : X_ZERO);
  assign frac   = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];

  always_comb begin
    res_d = '0;
    flg_d = '0;
    if (s2_q.sp) begin
      res_d = s2_q.sp_res;
      flg_d = s2_q.sp_flg;
    end else if (s2_q.zero) begin
      res_d = {s2_q.sign, {(W-1){1'b0}}};
    end else if (exp_r >= X_EMAX) begin
      res_d = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_d = 3'b010;
    end else if (exp_r < X_ONE) begin
      res_d = {s2_q.sign, {(W-1){1'b0}}};
      flg_d = 3'b001;
    end else begin
      res_d = {s2_q.sign, exp_r[EXP_W-1:0], frac};
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s3_vld_q <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      result_q <= '0;
      flg_q    <= '0;
      tag_q    <= '0;
    end else if (advance) begin
      s1_vld_q <= in_valid;
      s1_q     <= s1_d;
      s2_vld_q <= s1_vld_q;
      s2_q     <= s2_d;
      s3_vld_q <= s2_vld_q;
      result_q <= res_d;
      flg_q    <= flg_d;
      tag_q    <= s2_q.tag;
    end
  end

endmodule

// File: tb/tb_fp_arith_pipe.sv
// Directed bench for fp_arith_pipe: stimulus pushes hand-computed expectations
// into a scoreboard queue; a monitor pops and compares on each output handshake.
module tb_fp_arith_pipe;

  logic        clk = 1'b0;
  logic        areset;
  logic        in_valid, in_ready;
  logic [15:0] a, b, result;
  logic [1:0]  op;
  logic [3:0]  in_tag, out_tag;
  logic        out_valid, out_ready;
  logic [2:0]  flags;

  always #5 clk = ~clk;

  fp_arith_pipe dut (
    .clk       (clk),
    .areset    (areset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag),
    .flags     (flags)
  );

  typedef struct {
    logic [15:0] res;
    logic [3:0]  tag;
    logic [2:0]  flg;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compares every handshaken result against the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (areset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got tag %0d result 0x%0h, expected no output", out_tag, result);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("result tag%0d", e.tag), {16'h0, result}, {16'h0, e.res});
        check($sformatf("tag tag%0d", e.tag), {28'h0, out_tag}, {28'h0, e.tag});
        check($sformatf("flags tag%0d", e.tag), {29'h0, flags}, {29'h0, e.flg});
      end
    end
  end

  // Present one op (called at posedge+1), hold until accepted, then record expectation.
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic [1:0] iop,
                       input logic [3:0] itag, input logic [15:0] er, input logic [2:0] ef);
    logic acc;
    exp_t e;
    a = ia; b = ib; op = iop; in_tag = itag; in_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout tag%0d: in_ready never 1, expected acceptance", itag);
    end else begin
      e.res = er; e.tag = itag; e.flg = ef;
      sb_q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(negedge clk);
    check(name, sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat;
    int cnt;
    int seen;
    areset = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; in_tag = '0; out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_flags", flags, 0);
    @(posedge clk); #1;
    areset = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Basic add and its latency
    issue(16'h4100, 16'h4100, 2'b00, 4'd3, 16'h4500, 3'b000);
    lat = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
    end
    check("latency", lat, 3);
    @(posedge clk); #1;
    drain("drain_add");

    // Back-to-back sub then mul must leave on consecutive cycles
    issue(16'h4100, 16'h4100, 2'b01, 4'd4, 16'h0000, 3'b000);
    issue(16'h4100, 16'h4100, 2'b10, 4'd5, 16'h4640, 3'b000);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) cnt++;
      else if (cnt != 0) break;
    end
    check("b2b_consecutive", cnt, 2);
    @(posedge clk); #1;
    drain("drain_b2b");

    // Rounding ties, specials, signs
    issue(16'h3C00, 16'h1000, 2'b00, 4'd1,  16'h3C00, 3'b000);
    issue(16'h3C01, 16'h1000, 2'b00, 4'd2,  16'h3C02, 3'b000);
    issue(16'h7BFF, 16'h4000, 2'b10, 4'd12, 16'h7C00, 3'b010);
    issue(16'h7C00, 16'h7C00, 2'b01, 4'd13, 16'h7E00, 3'b100);
    issue(16'h3C00, 16'h3C00, 2'b11, 4'd14, 16'h7E00, 3'b100);
    issue(16'h0400, 16'h0400, 2'b10, 4'd15, 16'h0000, 3'b001);
    issue(16'h3C00, 16'h4000, 2'b01, 4'd6,  16'hBC00, 3'b000);
    issue(16'hC000, 16'h4000, 2'b10, 4'd7,  16'hC400, 3'b000);
    issue(16'h7E01, 16'h3C00, 2'b00, 4'd8,  16'h7E00, 3'b000);
    issue(16'h0000, 16'h7C00, 2'b10, 4'd9,  16'h7E00, 3'b100);
    issue(16'h7C00, 16'h3C00, 2'b00, 4'd10, 16'h7C00, 3'b000);
    issue(16'h3C00, 16'h3C00, 2'b01, 4'd11, 16'h0000, 3'b000);
    drain("drain_directed");

    // Backpressure: 5 ops while the consumer stalls for 4 cycles
    out_ready = 1'b0;
    fork
      begin
        issue(16'h3C00, 16'h3C00, 2'b00, 4'd8,  16'h4000, 3'b000);
        issue(16'h4000, 16'h3C00, 2'b00, 4'd9,  16'h4200, 3'b000);
        issue(16'h4200, 16'h3C00, 2'b00, 4'd10, 16'h4400, 3'b000);
        issue(16'h4400, 16'h4000, 2'b10, 4'd11, 16'h4800, 3'b000);
        issue(16'h4800, 16'h3C00, 2'b01, 4'd12, 16'h4700, 3'b000);
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        check("bp_out_valid", out_valid, 1);
        check("bp_hold_tag_a", out_tag, 8);
        @(posedge clk);
        #2;
        check("bp_in_ready_full", in_ready, 0);
        check("bp_hold_tag_b", out_tag, 8);
        check("bp_hold_result", result, 16'h4000);
        out_ready = 1'b1;
      end
    join
    drain("drain_bp");

    // Asynchronous reset with ops in flight
    out_ready = 1'b0;
    issue(16'h4100, 16'h4100, 2'b00, 4'd1, 16'h4500, 3'b000);
    issue(16'h3C00, 16'h3C00, 2'b00, 4'd2, 16'h4000, 3'b000);
    @(posedge clk); #1;
    check("inflight_out_valid", out_valid, 1);
    areset = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_result", result, 0);
    check("arst_out_tag", out_tag, 0);
    check("arst_flags", flags, 0);
    sb_q.delete();
    @(posedge clk); @(posedge clk); #1;
    areset = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_stale_output", seen, 0);

    // Pipe still works after reset
    @(posedge clk); #1;
    issue(16'h4100, 16'h4100, 2'b10, 4'd6, 16'h4640, 3'b000);
    drain("drain_post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_arith_pipe.md
Name: fp_arith_pipe

Overview:
- Parametrised successor to the team's half-precision floatingPoint unit: a fully pipelined IEEE-754-style add/sub/mul core with configurable exponent/mantissa widths.
- Adds a valid/ready handshake with backpressure, a tag passthrough, exception flags and defined special-value handling.
- Sits between the manipulator kinematics sequencer and the result register file; one operation accepted per clock when not stalled.

Parameters:
- EXP_W, 5, exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 10, stored mantissa (fraction) width; W = 1+EXP_W+MAN_W (16 at defaults).
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  system clock, rising edge.
- areset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand set present.
- in_ready  out  1  core can accept this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- op  in  2  00 add, 01 sub (a-b), 10 mul, 11 reserved.
- in_tag  in  TAG_W  caller tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- result  out  W  packed result.
- out_tag  out  TAG_W  tag of this result.
- flags  out  3  {invalid, overflow, underflow}.

Behaviour:
- Reset (areset=0, asynchronous): all stage valids=0; out_valid=0, result=0, out_tag=0, flags=0; in_ready=1 one cycle after release.
- Pipeline: 3 stages. S1 unpack, special detection, exponent compare/align (add/sub) or mantissa product (mul). S2 add/sub and leading-zero normalise. S3 round-to-nearest-even, overflow/underflow check, pack.
- Latency: an accepted op appears on out_valid exactly 3 cycles later when there is no stall.
- Advance = ~s3_valid | out_ready; in_ready = advance. All stages hold their contents when advance=0. Accept = in_valid & in_ready.
- Throughput: 1 op/cycle with out_ready held high; bubbles propagate as valid=0.
- out_valid/result/out_tag/flags stay stable while out_valid=1 & out_ready=0.
- Tags and flags travel with their operation; order is strictly FIFO.
- Subnormals: inputs with exp=0 are treated as signed zero (flush-to-zero). Results below the minimum normal become signed zero with underflow=1.
- Overflow: a rounded exponent >= all-ones gives signed Inf with overflow=1.
- NaN: any NaN input, Inf-Inf (effective subtract), 0*Inf, or op=11 gives canonical quiet NaN (sign 0, exp all-ones, fraction MSB 1, e.g. 0x7E00). invalid=1 only for Inf-Inf, 0*Inf and op=11. A propagated NaN input gives invalid=0.
- Inf operands otherwise return a correctly signed Inf with flags=0.
- Exact cancellation (x-x, x+(-x)) returns +0.
- Mul sign = sa^sb. Add/sub sign follows the larger magnitude.
- Rounding: guard, round and sticky bits are kept through alignment. Sticky is the OR of all shifted-out bits. Alignment shift saturates at MAN_W+3.
- Reset asserted mid-operation discards all in-flight ops; no output is produced for them.

Test Plan:
- add: a=0x4100, b=0x4100, op=00, tag=3 -> 3 cycles later out_valid=1, result=0x4500 (5.0), out_tag=3, flags=000.
- sub/mul back-to-back: 0x4100 with 0x4100, op=01 then op=10 on consecutive cycles -> results 0x0000 then 0x4640 (6.25) on consecutive cycles.
- Rounding ties: 0x3C00+0x1000 -> 0x3C00; 0x3C01+0x1000 -> 0x3C02.
- Specials: 0x7BFF*0x4000 -> 0x7C00 with overflow=1; 0x7C00-0x7C00 -> 0x7E00 with invalid=1; op=11 -> 0x7E00 with invalid=1; 0x0400*0x0400 -> 0x0000 with underflow=1.
- Backpressure: stream 5 ops, hold out_ready=0 for 4 cycles -> in_ready drops once the pipeline is full; no op is lost or duplicated; results emerge in order with their tags.
- Reset: pull areset low with 2 ops in flight -> outputs clear immediately; no stale out_valid after release.
